// File: rtl/rf_block_mover_pkg.sv
// Shared types and constants for the register-file block mover.
package rf_mover_pkg;

  // Controller states: idle, streaming in, streaming out, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } rf_mover_state_e;

  // Command direction encoding on cmd_dir_i.
  localparam logic DIR_LOAD = 1'b0;
  localparam logic DIR_DUMP = 1'b1;

endpackage

// File: rtl/rf_block_mover_out_reg.sv
// One-entry valid/ready holding register for the DUMP output stream.
// The owner only asserts fill when the entry is empty or draining, so the
// held word never changes while valid is high and the sink is stalled.
module rf_out_reg #(
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fill,
  input  logic [data_width_p-1:0] fill_data,
  input  logic                    ready,
  output logic                    valid,
  output logic [data_width_p-1:0] data
);

  // Load a new word on fill, otherwise empty the entry once the sink takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_block_mover.sv
// Block mover between valid/ready streams and the core register file.
// LOAD writes a stream of words to consecutive registers; DUMP reads
// consecutive registers out through a one-entry output register.
module rf_block_mover
  import rf_mover_pkg::*;
#(
  parameter int addr_width_p = 6,
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_dir_i,
  input  logic [addr_width_p-1:0] cmd_base_i,
  input  logic [addr_width_p:0]   cmd_count_i,
  input  logic                    in_valid_i,
  input  logic [data_width_p-1:0] in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [data_width_p-1:0] out_data_o,
  input  logic                    out_ready_i,
  output logic [addr_width_p-1:0] rf_w_addr_o,
  output logic                    rf_wen_o,
  output logic [data_width_p-1:0] rf_w_data_o,
  output logic [addr_width_p-1:0] rf_r_addr_o,
  input  logic [data_width_p-1:0] rf_r_val_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [addr_width_p-1:0] ptr_one  = 1;
  localparam logic [addr_width_p:0]   left_one = 1;

  rf_mover_state_e state, state_next;

  // ptr addresses the next register to touch; left counts words still to move
  // (for DUMP: reads still to issue into the output register).
  logic [addr_width_p-1:0] ptr;
  logic [addr_width_p:0]   left;

  logic accept;
  logic beat;
  logic space;
  logic fill;
  logic advance;

  assign accept = cmd_valid_i & cmd_ready_o;
  assign beat   = in_valid_i & in_ready_o;
  assign space  = ~out_valid_o | out_ready_i;

  // Write port follows the pointer; the enable is the input handshake itself.
  assign rf_w_addr_o = ptr;
  assign rf_w_data_o = in_data_i;
  assign rf_wen_o    = beat;

  // The pointer moves on every write beat and on every read that fills the
  // output register after the first (the first read happens at accept).
  assign advance = beat | (fill & (state == DUMP));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state handshake outputs.
  always_comb begin
    state_next  = state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    in_ready_o  = 1'b0;
    fill        = 1'b0;
    rf_r_addr_o = ptr;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        // Reading the base address directly lets the first DUMP word land in
        // the output register on the accept edge, giving one-cycle latency.
        rf_r_addr_o = cmd_base_i;
        if (cmd_valid_i) begin
          if (cmd_count_i == '0) begin
            state_next = DONE;
          end else if (cmd_dir_i == DIR_DUMP) begin
            state_next = DUMP;
            fill       = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && (left == left_one)) begin
          state_next = DONE;
        end
      end
      DUMP: begin
        if ((left != '0) && space) begin
          fill = 1'b1;
        end
        if ((left == '0) && space) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A reset cycle must not let a beat through to the register file.
    if (reset) begin
      in_ready_o = 1'b0;
    end
  end

  // Pointer and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr  <= '0;
      left <= '0;
    end else if (accept) begin
      if (fill) begin
        ptr  <= cmd_base_i + ptr_one;
        left <= cmd_count_i - left_one;
      end else begin
        ptr  <= cmd_base_i;
        left <= cmd_count_i;
      end
    end else if (advance) begin
      ptr  <= ptr + ptr_one;
      left <= left - left_one;
    end
  end

  rf_out_reg #(
    .data_width_p(data_width_p)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .fill     (fill),
    .fill_data(rf_r_val_i),
    .ready    (out_ready_i),
    .valid    (out_valid_o),
    .data     (out_data_o)
  );

endmodule
